fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data word width in bits; it SHALL match the write port of the downstream dual-clock FIFO.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning the number of requesters; legal values are 2..8.
REQ-003 The block SHALL have parameter MAX_BURST, default 16, meaning the maximum number of beats per grant.
REQ-004 The block SHALL have port wr_clk  input  1  FIFO write-domain clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port req_valid  input  NREQ  per-requester word valid.
REQ-007 The block SHALL have port req_last  input  NREQ  per-requester end-of-burst marker, qualified by req_valid.
REQ-008 The block SHALL have port req_data  input  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port req_ready  output  NREQ  per-requester accept; it is one-hot or zero.
REQ-010 The block SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-011 The block SHALL have port fifo_din  output  WIDTH  FIFO write data.
REQ-012 The block SHALL have port fifo_full  input  1  FIFO full flag.
REQ-013 The block SHALL have port grant_id  output  max(1,$clog2(NREQ))  index of the current owner.
REQ-014 The block SHALL have port busy  output  1  high while in BURST.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and BURST.
REQ-016 In IDLE, when any req_valid is high, the block SHALL pick a requester round-robin, starting at last_grant+1 mod NREQ, register grant_id, and enter BURST on the next edge; arbitration latency is 1 cycle.
REQ-017 In IDLE, the block SHALL hold req_ready=0 and fifo_wr_en=0.
REQ-018 In BURST, the block SHALL drive req_ready[grant_id] = !fifo_full; all other req_ready bits SHALL be 0.
REQ-019 In BURST, fifo_wr_en SHALL equal req_valid[grant_id] & !fifo_full, combinationally, and a beat transfers exactly when fifo_wr_en is high.
REQ-020 fifo_din SHALL equal req_data of grant_id in every state; its value is don't-care while fifo_wr_en=0.
REQ-021 A beat counter of width $clog2(MAX_BURST+1) SHALL clear on entry to BURST and increment on each transfer.
REQ-022 The burst SHALL end on the transfer carrying req_last, or on the transfer that makes the count equal MAX_BURST, whichever comes first.
REQ-023 When the burst ends, the block SHALL enter IDLE on the next edge and set last_grant to grant_id.
REQ-024 When fifo_full is asserted mid-burst, the block SHALL stall with no transfer and SHALL hold the grant and the count.
REQ-025 When the owner drops req_valid mid-burst, the block SHALL keep the grant with no timeout; requesters SHALL NOT drop valid before last.
REQ-026 When req_last and MAX_BURST coincide on the same transfer, the block SHALL treat it as a single end of burst.
REQ-027 Requests from non-owners SHALL be ignored until IDLE; the grant is never re-evaluated during a burst.
REQ-028 Round-robin SHALL guarantee that each continuously requesting requester is granted within NREQ bursts.
REQ-029 busy SHALL be 1 in BURST and 0 in IDLE.

Reset
REQ-030 Asserting rst SHALL immediately force state=IDLE, last_grant=NREQ-1 (so requester 0 wins first), count=0, and grant_id=0.
REQ-031 While rst is asserted, req_ready, fifo_wr_en, and busy SHALL be 0 regardless of the clock.
REQ-032 A reset mid-burst SHALL abandon the burst with no further FIFO write; recovery is the requester's responsibility.
REQ-033 Reset deassertion SHALL be synchronized to wr_clk by the integrator.

Structure
REQ-034 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default WIDTH, NREQ, and MAX_BURST constants.
REQ-035 One sub-module, fifo_rr_pick, SHALL be instantiated: a combinational rotating priority encoder (inputs req vector and last index; outputs pick index and any).
REQ-036 All state SHALL be registered in the wr_clk domain only; the block SHALL contain no CDC logic.

Verification
REQ-037 The bench SHALL cover this case: after reset, all four requesters valid, each sending 3 beats with last on beat 3 -> grants in order 0,1,2,3,0; 12 fifo_wr_en pulses; one idle cycle between bursts.
REQ-038 The bench SHALL cover this case: requester 2 streams 20 words with no last -> burst ends after 16 writes; requester 2 is regranted and the remaining 4 words follow.
REQ-039 The bench SHALL cover this case: fifo_full held high for 5 cycles at beat 4 of 8 -> req_ready=0 and no writes for those cycles; total writes = 8; grant unchanged.
REQ-040 The bench SHALL cover this case: rst pulsed at beat 2 of a burst -> fifo_wr_en=0 in the same cycle; post-reset first grant goes to requester 0.
REQ-041 The bench SHALL cover this case: req_last asserted on the 16th beat -> single burst end, with exactly one IDLE cycle before the next grant.
REQ-042 The bench SHALL cover this case: random valid/full traffic with a scoreboard -> per-requester data order preserved, no beat duplicated or lost, and req_ready one-hot or zero every cycle.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating priority encoder: the first requester after last_i (wrapping) wins.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   pick_o,
  output logic            any_o
);

  // Scan from the farthest candidate to the nearest so the nearest after last_i is kept.
  always_comb begin
    pick_o = '0;
    any_o  = |req_i;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_i[IW'((int'(last_i) + k) % NREQ)]) begin
        pick_o = IW'((int'(last_i) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst arbiter granting one of NREQ requesters the write port of a dual-clock FIFO.
//
// state | meaning
// IDLE  | no owner; arbitrate round-robin among valid requesters
// BURST | grant_id owns the FIFO until last beat or MAX_BURST beats
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     wr_clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din,
  input  logic                     fifo_full,
  output logic [idx_w(NREQ)-1:0]   grant_id,
  output logic                     busy
);

  localparam int GW = idx_w(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic [GW-1:0]     pick;
  logic              any_req;
  logic              burst_end;
  logic [WIDTH-1:0]  data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  fifo_rr_pick #(
    .NREQ (NREQ),
    .IW   (GW)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  assign cnt_inc   = cnt_q + CW'(1);
  assign burst_end = fifo_wr_en & (req_last[grant_q] | (cnt_inc == CNT_MAX));
  assign fifo_din  = data_arr[grant_q];
  assign grant_id  = grant_q;

  // State register; reset makes requester 0 the first winner.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: grant is only chosen in IDLE and held for the whole burst.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BURST;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (fifo_wr_en) begin
          cnt_d = cnt_inc;
        end
        if (burst_end) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    busy       = 1'b0;
    if ((state_q == BURST) && !rst) begin
      busy               = 1'b1;
      req_ready[grant_q] = !fifo_full;
      fifo_wr_en         = req_valid[grant_q] & !fifo_full;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised bench for fifo_wr_arbiter with a queue-based reference model.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 32;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;
  localparam int GW        = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic                  wr_clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_din;
  logic                  fifo_full = 1'b0;
  logic [GW-1:0]         grant_id;
  logic                  busy;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .NREQ      (NREQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // pending words per requester, head is the next beat to be written
  beat_t src_q [NREQ][$];
  bit [NREQ-1:0] vmask;
  bit            full_i;

  // reference model: who owns the FIFO and how many beats it has moved
  int m_busy, m_owner, m_last, m_beats;
  logic             e_busy, e_wren;
  logic [NREQ-1:0]  e_ready;
  logic [WIDTH-1:0] e_din;

  // observations of the DUT for scenario-level checks
  int obs_grants[$];
  int obs_wstart[$];
  int obs_writes, gaps;
  bit seen_busy, prev_busy;

  int vec = 0;
  int miss = 0;

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load(input int r, input int n, input bit last_end);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = $urandom;
      b.last = last_end && (k == n - 1);
      src_q[r].push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
    vmask = '1; full_i = 1'b0;
    m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_beats = 0;
    obs_grants.delete(); obs_wstart.delete();
    obs_writes = 0; gaps = 0; seen_busy = 1'b0; prev_busy = 1'b0;
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    rst = 1'b0;
  endtask

  // apply this cycle's inputs, derive expected outputs, record observations
  task automatic drive();
    @(negedge wr_clk);
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i] = vmask[i];
        req_last[i]  = src_q[i][0].last;
        req_data[i*WIDTH +: WIDTH] = src_q[i][0].data;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*WIDTH +: WIDTH] = $urandom;
      end
    end
    fifo_full = full_i;
    #1;
    e_busy = (m_busy != 0);
    e_ready = '0; e_wren = 1'b0; e_din = '0;
    if (m_busy != 0) begin
      e_ready[m_owner] = !full_i;
      e_wren = req_valid[m_owner] && !full_i;
      if (src_q[m_owner].size() > 0) e_din = src_q[m_owner][0].data;
    end
    if (busy && !prev_busy) begin
      obs_grants.push_back(int'(grant_id));
      obs_wstart.push_back(obs_writes);
    end
    if (busy) seen_busy = 1'b1;
    if (!busy && seen_busy && pending()) gaps++;
    if (fifo_wr_en) obs_writes++;
    prev_busy = busy;
  endtask

  // advance the model across the coming rising edge
  task automatic advance();
    beat_t b;
    if (m_busy == 0) begin
      if (|req_valid) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (req_valid[(m_last + k) % NREQ]) begin
            m_owner = (m_last + k) % NREQ;
            break;
          end
        end
        m_busy = 1; m_beats = 0;
      end
    end else if (req_valid[m_owner] && !full_i) begin
      b = src_q[m_owner].pop_front();
      m_beats++;
      if (b.last || m_beats == MAX_BURST) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
    @(posedge wr_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1; req_last = '0; fifo_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge wr_clk);
      vec++;
      if (busy !== 1'b0 || req_ready !== '0 || fifo_wr_en !== 1'b0 || grant_id !== '0) begin
        miss++;
        $display("FAIL reset_outputs c=%0d busy=%b ready=%b wr_en=%b grant=%0d want 0 0 0 0",
                 c, busy, req_ready, fifo_wr_en, grant_id);
      end
    end
    do_reset();
  endtask

  task automatic test_four_bursts();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int r = 0; r < NREQ; r++) load(r, 3, 1'b1);
    for (int c = 0; c < 100 && (pending() || m_busy != 0); c++) begin
      drive();
      vec++;
      if (busy !== e_busy || req_ready !== e_ready || fifo_wr_en !== e_wren ||
          (e_wren && fifo_din !== e_din) || (e_busy && grant_id !== GW'(m_owner))) begin
        miss++;
        $display("FAIL rr4 t=%0t busy=%b/%b ready=%b/%b wr_en=%b/%b din=%h/%h grant=%0d/%0d",
                 $time, busy, e_busy, req_ready, e_ready, fifo_wr_en, e_wren, fifo_din, e_din, grant_id, m_owner);
      end
      advance();
    end
    vec++;
    if (obs_writes !== 12) begin miss++; $display("FAIL rr4_writes got %0d want 12", obs_writes); end
    vec++;
    if (gaps !== 3) begin miss++; $display("FAIL rr4_idle_gaps got %0d want 3", gaps); end
    load(0, 3, 1'b1);
    for (int c = 0; c < 40 && (pending() || m_busy != 0); c++) begin
      drive();
      vec++;
      if (busy !== e_busy || fifo_wr_en !== e_wren || (e_wren && fifo_din !== e_din)) begin
        miss++;
        $display("FAIL rr4_again busy=%b/%b wr_en=%b/%b din=%h/%h", busy, e_busy, fifo_wr_en, e_wren, fifo_din, e_din);
      end
      advance();
    end
    vec++;
    if (obs_grants.size() != 5) begin
      miss++; $display("FAIL rr4_grant_count got %0d want 5", obs_grants.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vec++;
        if (obs_grants[i] != exp_g[i]) begin
          miss++; $display("FAIL rr4_grant_order idx=%0d got %0d want %0d", i, obs_grants[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_max_burst();
    do_reset();
    load(2, 20, 1'b1);
    for (int c = 0; c < 100 && (pending() || m_busy != 0); c++) begin
      drive();
      vec++;
      if (busy !== e_busy || req_ready !== e_ready || fifo_wr_en !== e_wren ||
          (e_wren && fifo_din !== e_din) || (e_busy && grant_id !== GW'(m_owner))) begin
        miss++;
        $display("FAIL maxburst t=%0t busy=%b/%b ready=%b/%b wr_en=%b/%b din=%h/%h grant=%0d/%0d",
                 $time, busy, e_busy, req_ready, e_ready, fifo_wr_en, e_wren, fifo_din, e_din, grant_id, m_owner);
      end
      advance();
    end
    vec++;
    if (obs_writes !== 20) begin miss++; $display("FAIL maxburst_writes got %0d want 20", obs_writes); end
    vec++;
    if (obs_grants.size() != 2 || obs_grants[0] != 2 || obs_grants[1] != 2) begin
      miss++; $display("FAIL maxburst_grants got %p want two grants to 2", obs_grants);
    end else begin
      vec++;
      if (obs_wstart[1] - obs_wstart[0] != 16) begin
        miss++; $display("FAIL maxburst_len got %0d want 16", obs_wstart[1] - obs_wstart[0]);
      end
    end
  endtask

  task automatic test_full_stall();
    int stall_left = 0;
    bit stalled = 1'b0;
    do_reset();
    load(1, 8, 1'b1);
    for (int c = 0; c < 100 && (pending() || m_busy != 0); c++) begin
      if (!stalled && m_busy != 0 && m_beats == 3) begin stall_left = 5; stalled = 1'b1; end
      full_i = (stall_left > 0);
      drive();
      vec++;
      if (busy !== e_busy || req_ready !== e_ready || fifo_wr_en !== e_wren ||
          (e_wren && fifo_din !== e_din) || (e_busy && grant_id !== GW'(m_owner))) begin
        miss++;
        $display("FAIL stall t=%0t busy=%b/%b ready=%b/%b wr_en=%b/%b din=%h/%h grant=%0d/%0d",
                 $time, busy, e_busy, req_ready, e_ready, fifo_wr_en, e_wren, fifo_din, e_din, grant_id, m_owner);
      end
      if (full_i) begin
        vec++;
        if (req_ready !== '0 || fifo_wr_en !== 1'b0 || grant_id !== 2'd1 || busy !== 1'b1) begin
          miss++;
          $display("FAIL stall_hold ready=%b wr_en=%b grant=%0d busy=%b want 0 0 1 1", req_ready, fifo_wr_en, grant_id, busy);
        end
      end
      advance();
      if (stall_left > 0) stall_left--;
    end
    full_i = 1'b0;
    vec++;
    if (!stalled) begin miss++; $display("FAIL stall_reached got 0 want 1"); end
    vec++;
    if (obs_writes !== 8) begin miss++; $display("FAIL stall_writes got %0d want 8", obs_writes); end
    vec++;
    if (obs_grants.size() != 1) begin miss++; $display("FAIL stall_grants got %0d grants want 1", obs_grants.size()); end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    do_reset();
    load(3, 6, 1'b1);
    for (int c = 0; c < 50; c++) begin
      drive();
      vec++;
      if (busy !== e_busy || fifo_wr_en !== e_wren || (e_wren && fifo_din !== e_din)) begin
        miss++;
        $display("FAIL rstmid_pre busy=%b/%b wr_en=%b/%b din=%h/%h", busy, e_busy, fifo_wr_en, e_wren, fifo_din, e_din);
      end
      if (m_busy != 0 && m_beats == 1) begin hit = 1'b1; break; end
      advance();
    end
    vec++;
    if (!hit) begin
      miss++; $display("FAIL rstmid_reach got no beat 2 want beat 2 within 50 cycles");
    end else begin
      #1 rst = 1'b1;
      #1;
      vec++;
      if (fifo_wr_en !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || grant_id !== '0) begin
        miss++;
        $display("FAIL rstmid_async wr_en=%b ready=%b busy=%b grant=%0d want 0 0 0 0", fifo_wr_en, req_ready, busy, grant_id);
      end
    end
    do_reset();
    load(3, 2, 1'b1);
    load(0, 2, 1'b1);
    for (int c = 0; c < 40 && (pending() || m_busy != 0); c++) begin
      drive();
      vec++;
      if (busy !== e_busy || fifo_wr_en !== e_wren || (e_wren && fifo_din !== e_din)) begin
        miss++;
        $display("FAIL rstmid_post busy=%b/%b wr_en=%b/%b din=%h/%h", busy, e_busy, fifo_wr_en, e_wren, fifo_din, e_din);
      end
      advance();
    end
    vec++;
    if (obs_grants.size() != 2 || obs_grants[0] != 0 || obs_grants[1] != 3) begin
      miss++; $display("FAIL rstmid_grants got %p want 0 then 3", obs_grants);
    end
  endtask

  task automatic test_last_at_max();
    do_reset();
    load(0, 16, 1'b1);
    load(1, 2, 1'b1);
    for (int c = 0; c < 100 && (pending() || m_busy != 0); c++) begin
      drive();
      vec++;
      if (busy !== e_busy || req_ready !== e_ready || fifo_wr_en !== e_wren ||
          (e_wren && fifo_din !== e_din) || (e_busy && grant_id !== GW'(m_owner))) begin
        miss++;
        $display("FAIL lastmax t=%0t busy=%b/%b ready=%b/%b wr_en=%b/%b din=%h/%h grant=%0d/%0d",
                 $time, busy, e_busy, req_ready, e_ready, fifo_wr_en, e_wren, fifo_din, e_din, grant_id, m_owner);
      end
      advance();
    end
    vec++;
    if (gaps !== 1) begin miss++; $display("FAIL lastmax_idle got %0d want 1", gaps); end
    vec++;
    if (obs_writes !== 18) begin miss++; $display("FAIL lastmax_writes got %0d want 18", obs_writes); end
    vec++;
    if (obs_grants.size() != 2 || obs_grants[0] != 0 || obs_grants[1] != 1) begin
      miss++; $display("FAIL lastmax_grants got %p want 0 then 1", obs_grants);
    end else begin
      vec++;
      if (obs_wstart[1] - obs_wstart[0] != 16) begin
        miss++; $display("FAIL lastmax_len got %0d want 16", obs_wstart[1] - obs_wstart[0]);
      end
    end
  endtask

  task automatic test_random();
    int total = 0;
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      for (int b = 0; b < 3; b++) begin
        int n = $urandom_range(1, 20);
        load(r, n, 1'b1);
        total += n;
      end
    end
    for (int c = 0; c < 4000 && (pending() || m_busy != 0); c++) begin
      for (int i = 0; i < NREQ; i++) vmask[i] = ($urandom_range(0, 99) < 85);
      full_i = ($urandom_range(0, 3) == 0);
      drive();
      vec++;
      if (busy !== e_busy || req_ready !== e_ready || fifo_wr_en !== e_wren ||
          (e_wren && fifo_din !== e_din) || (e_busy && grant_id !== GW'(m_owner))) begin
        miss++;
        $display("FAIL random t=%0t busy=%b/%b ready=%b/%b wr_en=%b/%b din=%h/%h grant=%0d/%0d",
                 $time, busy, e_busy, req_ready, e_ready, fifo_wr_en, e_wren, fifo_din, e_din, grant_id, m_owner);
      end
      vec++;
      if (!$onehot0(req_ready)) begin
        miss++; $display("FAIL random_onehot ready=%b want one-hot or zero", req_ready);
      end
      advance();
    end
    vmask = '1; full_i = 1'b0;
    vec++;
    if (pending() || obs_writes != total) begin
      miss++; $display("FAIL random_drain writes=%0d want %0d (pending=%0d)", obs_writes, total, pending());
    end
  endtask

  initial begin
    test_reset();
    test_four_bursts();
    test_max_burst();
    test_full_stall();
    test_reset_mid();
    test_last_at_max();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
